// File: rtl/ex_div.sv
// ex_div: iterative restoring 32-bit divider (DIV/DIVU) for the EX stage, one quotient bit per cycle.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stallreq
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t             state, state_nxt;
    logic [5:0]         cnt, cnt_nxt;
    logic [2*WIDTH:0]   work, work_nxt, shifted;
    logic [WIDTH-1:0]   divisor, divisor_nxt, abs1, abs2, quotient, remainder;
    logic [WIDTH:0]     trial;
    logic               neg_q, neg_q_nxt, neg_r, neg_r_nxt, abort;
    always_comb begin
        abs1      = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2      = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        abort     = annul || !start;
        shifted   = work << 1;
        trial     = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
        state_nxt   = state;
        cnt_nxt     = cnt;
        work_nxt    = work;
        divisor_nxt = divisor;
        neg_q_nxt   = neg_q;
        neg_r_nxt   = neg_r;
        case (state)
            FREE: begin
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_nxt = BYZERO;
                    end else begin
                        state_nxt   = ON;
                        divisor_nxt = abs2;
                        work_nxt    = {{(WIDTH+1){1'b0}}, abs1};
                        cnt_nxt     = '0;
                        neg_q_nxt   = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_r_nxt   = signed_div && opdata1[WIDTH-1];
                    end
                end
            end
            BYZERO: begin
                state_nxt = abort ? FREE : END;
                work_nxt  = abort ? work : '0;
            end
            ON: begin
                if (abort) begin
                    state_nxt = FREE;
                end else begin
                    // trial sign bit clear means the shifted partial remainder covers the divisor
                    work_nxt  = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};
                    cnt_nxt   = cnt + 6'd1;
                    state_nxt = (cnt == 6'(WIDTH-1)) ? END : ON;
                end
            end
            default: state_nxt = FREE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FREE;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            work    <= work_nxt;
            divisor <= divisor_nxt;
            neg_q   <= neg_q_nxt;
            neg_r   <= neg_r_nxt;
        end
    end
    assign quotient  = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign remainder = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    assign ready     = (state == END);
    assign result    = ready ? {remainder, quotient} : '0;
    assign stallreq  = start && !ready;
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div covering latency, signedness, divide-by-zero, annul and async reset.
module tb_ex_div;
    logic        clk, rst, start, signed_div, annul;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready, stallreq;
    int          checks = 0;
    int          fails = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .result(result), .ready(ready), .stallreq(stallreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starts at #1 after a rising edge with the DUT in FREE; checks every cycle up to and including END.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit keep, input string name);
        signed_div = sgn;
        opdata1 = a;
        opdata2 = b;
        start = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || stallreq !== 1'b1 || result !== 64'h0) begin
                fails++;
                $display("FAIL %s busy cycle T+%0d: ready=%b stallreq=%b result=%h, required ready=0 stallreq=1 result=0",
                         name, i, ready, stallreq, result);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || stallreq !== 1'b0 || result !== exp) begin
            fails++;
            $display("FAIL %s done T+%0d: ready=%b stallreq=%b result=%h, required ready=1 stallreq=0 result=%h",
                     name, lat, ready, stallreq, result, exp);
        end
        @(posedge clk); #1;
        if (!keep) begin
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || stallreq !== 1'b0 || result !== 64'h0) begin
                fails++;
                $display("FAIL %s idle after: ready=%b stallreq=%b result=%h, required all 0", name, ready, stallreq, result);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
        #2;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0 || stallreq !== 1'b0) begin
            fails++;
            $display("FAIL reset: ready=%b result=%h stallreq=%b, required 0/0/0", ready, result, stallreq);
        end
        start = 1'b1;
        #1;
        checks++;
        if (stallreq !== 1'b1 || ready !== 1'b0) begin
            fails++;
            $display("FAIL reset stallreq follows start: stallreq=%b ready=%b, required 1/0", stallreq, ready);
        end
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_divu;
        do_div(1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, 33, 1'b0, "divu_100_7");
        do_div(1'b0, 32'hFFFFFFFF,  32'd1,          64'h00000000_FFFFFFFF, 33, 1'b0, "divu_max_1");
        do_div(1'b0, 32'd7,         32'd100,        64'h00000007_00000000, 33, 1'b0, "divu_7_100");
        do_div(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   64'h00000000_00000001, 33, 1'b0, "divu_max_max");
        do_div(1'b0, 32'hFFFFFF9C,  32'd7,          64'h00000002_24924916, 33, 1'b0, "divu_big_7");
    endtask

    task automatic test_div_signed;
        do_div(1'b1, 32'hFFFFFF9C,  32'd7,          64'hFFFFFFFE_FFFFFFF2, 33, 1'b0, "div_m100_7");
        do_div(1'b1, 32'd100,       32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 33, 1'b0, "div_100_m7");
        do_div(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33, 1'b0, "div_m100_m7");
        do_div(1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 33, 1'b0, "div_overflow");
    endtask

    task automatic test_byzero;
        do_div(1'b0, 32'd5, 32'd0, 64'h0, 2, 1'b0, "divu_5_0");
        do_div(1'b1, 32'hFFFFFF9C, 32'd0, 64'h0, 2, 1'b0, "div_m100_0");
    endtask

    task automatic test_annul;
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i == 10) annul = 1'b1;
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || stallreq !== 1'b1) begin
                fails++;
                $display("FAIL annul busy T+%0d: ready=%b stallreq=%b, required 0/1", i, ready, stallreq);
            end
            @(posedge clk); #1;
        end
        annul = 1'b0;
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0, "after_annul_9_3");
    endtask

    task automatic test_back_to_back;
        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1, "b2b_first");
        do_div(1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33, 1'b0, "b2b_second");
    endtask

    task automatic test_async_reset;
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0 || stallreq !== 1'b1) begin
            fails++;
            $display("FAIL async reset mid-ON: ready=%b result=%h stallreq=%b, required 0/0/1", ready, result, stallreq);
        end
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0, "after_reset_9_3");
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (33) begin @(posedge clk); #1; end
        checks++;
        if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
            fails++;
            $display("FAIL async reset pre END: ready=%b result=%h, required 1/00000002_0000000e", ready, result);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            fails++;
            $display("FAIL async reset in END: ready=%b result=%h, required 0/0", ready, result);
        end
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0, "after_end_reset_9_3");
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_byzero();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
